// File: rtl/ascon_plaintext_absorb_pkg.sv
// Shared types and helpers for the ASCON-128 plaintext absorb stage:
// state type, FSM encoding, round constants and last-block padding/masking.
package ascon_pack;

    typedef logic [4:0][63:0] type_state;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ABSORB = 2'd1,
        S_PERM   = 2'd2,
        S_DONE   = 2'd3
    } fsm_e;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    // Constant for round index r (0..11): high nibble 15-r, low nibble r.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'd15 - r, r};
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int unsigned n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Keeps bytes 0..n-1, byte 0 being the most significant byte.
    function automatic logic [63:0] byte_mask(input logic [2:0] n);
        return ~(64'hFFFF_FFFF_FFFF_FFFF >> {n, 3'b000});
    endfunction

    // Padding byte placed at byte position n; 7-n equals ~n on three bits.
    function automatic logic [63:0] pad_word(input logic [2:0] n);
        return {56'd0, PAD_BYTE} << {~n, 3'b000};
    endfunction

endpackage

// File: rtl/ascon_plaintext_absorb_round.sv
// One combinational ASCON permutation round: constant addition, bitsliced
// 5-bit S-box layer and per-word linear diffusion.
module ascon_round
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);

    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] t0, t1, t2, t3, t4;

    always_comb begin
        x0 = state_i[0] ^ state_i[4];
        x1 = state_i[1];
        x2 = state_i[2] ^ {56'd0, round_const(round_i)} ^ state_i[1];
        x3 = state_i[3];
        x4 = state_i[4] ^ state_i[3];

        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;

        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;

        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;

        state_o[0] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
        state_o[1] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
        state_o[2] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
        state_o[3] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
        state_o[4] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    end

endmodule

// File: rtl/ascon_plaintext_absorb.sv
// ASCON-128 plaintext absorb: XORs 64-bit blocks into state[0], emits
// ciphertext, permutes between blocks and hands the padded state onward.
module ascon_plaintext_absorb
    import ascon_pack::*;
#(
    parameter int unsigned PERM_ROUNDS = 6,
    parameter bit          DOMAIN_SEP  = 1'b1
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  type_state   state_i,
    input  logic        state_valid_i,
    output logic        state_ready_o,
    input  logic [63:0] data_i,
    input  logic [3:0]  data_bytes_i,
    input  logic        data_last_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [63:0] cipher_o,
    output logic [3:0]  cipher_bytes_o,
    output logic        cipher_valid_o,
    output type_state   state_o,
    output logic        state_valid_o,
    input  logic        state_ready_i,
    output logic        busy_o
);

    localparam logic [3:0] RND_FIRST = 4'(12 - PERM_ROUNDS);
    localparam logic [3:0] RND_LAST  = 4'd11;

    fsm_e        fsm_q, fsm_d;
    type_state   st_q, st_d, st_rnd;
    logic [3:0]  rnd_q, rnd_d;
    logic [63:0] cipher_q, cipher_d;
    logic [3:0]  cbytes_q, cbytes_d;
    logic        cvalid_q, cvalid_d;
    logic [2:0]  n_last;
    logic [63:0] mask, mixed;

    ascon_round u_round (
        .state_i (st_q),
        .round_i (rnd_q),
        .state_o (st_rnd)
    );

    // Out-of-range byte counts on the last block behave as 7.
    assign n_last = (data_bytes_i > 4'd7) ? 3'd7 : data_bytes_i[2:0];
    assign mask   = byte_mask(n_last);
    assign mixed  = st_q[0] ^ data_i;

    always_comb begin
        fsm_d    = fsm_q;
        st_d     = st_q;
        rnd_d    = rnd_q;
        cipher_d = cipher_q;
        cbytes_d = cbytes_q;
        cvalid_d = 1'b0;
        case (fsm_q)
            S_IDLE: if (state_valid_i) begin
                st_d    = state_i;
                st_d[4] = state_i[4] ^ {63'd0, DOMAIN_SEP};
                fsm_d   = S_ABSORB;
            end
            S_ABSORB: if (data_valid_i) begin
                cvalid_d = 1'b1;
                if (data_last_i) begin
                    cipher_d = mixed & mask;
                    cbytes_d = {1'b0, n_last};
                    st_d[0]  = (st_q[0] ^ (data_i & mask)) ^ pad_word(n_last);
                    fsm_d    = S_DONE;
                end else begin
                    cipher_d = mixed;
                    cbytes_d = 4'd8;
                    st_d[0]  = mixed;
                    rnd_d    = RND_FIRST;
                    fsm_d    = S_PERM;
                end
            end
            S_PERM: begin
                st_d  = st_rnd;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == RND_LAST) fsm_d = S_ABSORB;
            end
            S_DONE: if (state_ready_i) fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            fsm_q    <= S_IDLE;
            st_q     <= '0;
            rnd_q    <= '0;
            cipher_q <= '0;
            cbytes_q <= '0;
            cvalid_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            st_q     <= st_d;
            rnd_q    <= rnd_d;
            cipher_q <= cipher_d;
            cbytes_q <= cbytes_d;
            cvalid_q <= cvalid_d;
        end
    end

    assign state_ready_o  = (fsm_q == S_IDLE) && !reset_i;
    assign data_ready_o   = (fsm_q == S_ABSORB);
    assign busy_o         = (fsm_q != S_IDLE);
    assign state_valid_o  = (fsm_q == S_DONE);
    assign state_o        = st_q;
    assign cipher_o       = cipher_q;
    assign cipher_bytes_o = cbytes_q;
    assign cipher_valid_o = cvalid_q;

endmodule

// File: tb/tb_ascon_plaintext_absorb.sv
// Bench for ascon_plaintext_absorb: two instances (no / with domain separation)
// driven in lockstep and checked against a column-wise S-box ASCON model.
module tb_ascon_plaintext_absorb;
    import ascon_pack::*;

    localparam int PR = 6;

    localparam logic [4:0] SBOX [0:31] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b0;
    type_state   state_i = '0;
    logic        state_valid_i = 1'b0;
    logic [63:0] data_i = '0;
    logic [3:0]  data_bytes_i = '0;
    logic        data_last_i = 1'b0;
    logic        data_valid_i = 1'b0;
    logic        state_ready_i = 1'b0;

    logic        state_ready_o  [2];
    logic        data_ready_o   [2];
    logic [63:0] cipher_o       [2];
    logic [3:0]  cipher_bytes_o [2];
    logic        cipher_valid_o [2];
    type_state   state_o        [2];
    logic        state_valid_o  [2];
    logic        busy_o         [2];

    type_state ms [2];
    int errs = 0;
    int checks = 0;

    always #5 clock_i = ~clock_i;

    ascon_plaintext_absorb #(.PERM_ROUNDS(PR), .DOMAIN_SEP(1'b0)) dut0 (
        .clock_i(clock_i), .reset_i(reset_i), .state_i(state_i), .state_valid_i(state_valid_i),
        .state_ready_o(state_ready_o[0]), .data_i(data_i), .data_bytes_i(data_bytes_i),
        .data_last_i(data_last_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o[0]),
        .cipher_o(cipher_o[0]), .cipher_bytes_o(cipher_bytes_o[0]), .cipher_valid_o(cipher_valid_o[0]),
        .state_o(state_o[0]), .state_valid_o(state_valid_o[0]), .state_ready_i(state_ready_i),
        .busy_o(busy_o[0]));

    ascon_plaintext_absorb #(.PERM_ROUNDS(PR), .DOMAIN_SEP(1'b1)) dut1 (
        .clock_i(clock_i), .reset_i(reset_i), .state_i(state_i), .state_valid_i(state_valid_i),
        .state_ready_o(state_ready_o[1]), .data_i(data_i), .data_bytes_i(data_bytes_i),
        .data_last_i(data_last_i), .data_valid_i(data_valid_i), .data_ready_o(data_ready_o[1]),
        .cipher_o(cipher_o[1]), .cipher_bytes_o(cipher_bytes_o[1]), .cipher_valid_o(cipher_valid_o[1]),
        .state_o(state_o[1]), .state_valid_o(state_valid_o[1]), .state_ready_i(state_ready_i),
        .busy_o(busy_o[1]));

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Reference permutation: S-box applied per bit column via lookup table.
    function automatic type_state perm(input type_state s);
        type_state t;
        logic [4:0] v;
        t = s;
        for (int r = 12 - PR; r < 12; r++) begin
            t[2] = t[2] ^ 64'(((15 - r) << 4) | r);
            for (int b = 0; b < 64; b++) begin
                v = {t[0][b], t[1][b], t[2][b], t[3][b], t[4][b]};
                {t[0][b], t[1][b], t[2][b], t[3][b], t[4][b]} = SBOX[v];
            end
            t[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
            t[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
            t[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
            t[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
            t[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
        end
        return t;
    endfunction

    function automatic type_state rand_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom(), $urandom()};
        return s;
    endfunction

    task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic load(input type_state s);
        for (int k = 0; k < 2; k++) chk($sformatf("idle_ready%0d", k), state_ready_o[k], 1);
        state_i = s;
        state_valid_i = 1'b1;
        tick();
        state_valid_i = 1'b0;
        ms[0] = s;
        ms[1] = s;
        ms[1][4] = ms[1][4] ^ 64'h1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("load_busy%0d", k), busy_o[k], 1);
            chk($sformatf("load_dready%0d", k), data_ready_o[k], 1);
            chk($sformatf("load_state%0d", k), state_o[k], ms[k]);
        end
    endtask

    task automatic send(input logic [63:0] d, input bit last, input int n);
        int ne, cnt;
        logic [63:0] m, p, expc;
        ne = (n > 7) ? 7 : n;
        if (last && n > 7) $display("note: protocol error, data_bytes_i=%0d exceeds 7", n);
        data_i = d;
        data_last_i = last;
        data_bytes_i = last ? 4'(n) : 4'd0;
        data_valid_i = 1'b1;
        state_valid_i = 1'b1;           // must be ignored outside IDLE
        state_i = rand_state();
        tick();
        data_valid_i = 1'b0;
        data_last_i = 1'b0;
        state_valid_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("cvalid%0d", k), cipher_valid_o[k], 1);
            if (!last) begin
                expc = ms[k][0] ^ d;
                ms[k][0] = expc;
                chk($sformatf("cbytes%0d", k), cipher_bytes_o[k], 8);
            end else begin
                m = '0;
                p = '0;
                for (int i = 0; i < 8; i++) begin
                    if (i < ne) m[63 - 8*i -: 8] = 8'hFF;
                    if (i == ne) p[63 - 8*i -: 8] = 8'h80;
                end
                expc = (ms[k][0] ^ d) & m;
                ms[k][0] = ms[k][0] ^ (d & m) ^ p;
                chk($sformatf("cbytes%0d", k), cipher_bytes_o[k], ne);
            end
            chk($sformatf("cipher%0d", k), cipher_o[k], expc);
        end
        if (last) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("last_svalid%0d", k), state_valid_o[k], 1);
                chk($sformatf("last_dready%0d", k), data_ready_o[k], 0);
                chk($sformatf("last_state%0d", k), state_o[k], ms[k]);
            end
        end else begin
            cnt = 0;
            while (data_ready_o[0] !== 1'b1 && cnt < 20) begin
                cnt++;
                tick();
                if (cnt == 1) chk("cvalid_pulse", cipher_valid_o[0], 0);
            end
            chk("ready_low_cycles", cnt, PR);
            for (int k = 0; k < 2; k++) begin
                ms[k] = perm(ms[k]);
                chk($sformatf("perm_dready%0d", k), data_ready_o[k], 1);
                chk($sformatf("perm_state%0d", k), state_o[k], ms[k]);
            end
        end
    endtask

    task automatic release_state();
        state_ready_i = 1'b1;
        tick();
        state_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rel_sready%0d", k), state_ready_o[k], 1);
            chk($sformatf("rel_busy%0d", k), busy_o[k], 0);
            chk($sformatf("rel_svalid%0d", k), state_valid_o[k], 0);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_sready%0d", tag, k), state_ready_o[k], 0);
            chk($sformatf("%s_busy%0d", tag, k), busy_o[k], 0);
            chk($sformatf("%s_dready%0d", tag, k), data_ready_o[k], 0);
            chk($sformatf("%s_svalid%0d", tag, k), state_valid_o[k], 0);
            chk($sformatf("%s_cvalid%0d", tag, k), cipher_valid_o[k], 0);
            chk($sformatf("%s_cipher%0d", tag, k), {cipher_bytes_o[k], cipher_o[k]}, 0);
            chk($sformatf("%s_state%0d", tag, k), state_o[k], 0);
        end
    endtask

    initial begin
        type_state snew;
        int nblk;

        // Reset state
        #1 reset_i = 1'b1;
        #1 chk_reset_outputs("rst");
        tick();
        tick();
        reset_i = 1'b0;
        #1 for (int k = 0; k < 2; k++) chk($sformatf("post_rst_sready%0d", k), state_ready_o[k], 1);
        tick();

        // Zero state, one full block, then close the message
        load('0);
        send(64'h0123456789ABCDEF, 1'b0, 0);
        send({$urandom(), $urandom()}, 1'b1, 5);
        release_state();

        // Zero state, last block of 3 bytes
        load('0);
        send(64'hAABBCCDDEEFF1122, 1'b1, 3);
        chk("tp_last3_cipher", cipher_o[0], 64'hAABBCC0000000000);
        chk("tp_last3_s0", state_o[0][0], 64'hAABBCC8000000000);

        // Hold in DONE with backpressure
        for (int i = 0; i < 10; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("hold_svalid%0d", k), state_valid_o[k], 1);
                chk($sformatf("hold_sready%0d", k), state_ready_o[k], 0);
                chk($sformatf("hold_state%0d", k), state_o[k], ms[k]);
            end
        end

        // Transfer with a new state offered in the same cycle: only the transfer happens
        snew = '0;
        state_i = snew;
        state_valid_i = 1'b1;
        state_ready_i = 1'b1;
        tick();
        state_ready_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("xfer_idle%0d", k), state_ready_o[k], 1);
            chk($sformatf("xfer_busy%0d", k), busy_o[k], 0);
            chk($sformatf("xfer_state%0d", k), state_o[k], ms[k]);
        end
        state_valid_i = 1'b0;
        load(snew);

        // Empty message on zero state
        send(64'hDEADBEEFCAFEF00D, 1'b1, 0);
        chk("empty_cipher", cipher_o[0], 64'h0);
        chk("empty_s0", state_o[0][0], 64'h8000000000000000);
        chk("empty_ds_s4", state_o[1][4], 64'h1);
        chk("empty_nods_s4", state_o[0][4], 64'h0);
        release_state();

        // Random 3-block message
        load(rand_state());
        send({$urandom(), $urandom()}, 1'b0, 0);
        send({$urandom(), $urandom()}, 1'b0, 0);
        send({$urandom(), $urandom()}, 1'b1, int'($urandom_range(0, 7)));
        release_state();

        // Random messages of random length
        for (int msg = 0; msg < 5; msg++) begin
            load(rand_state());
            nblk = int'($urandom_range(0, 3));
            for (int b = 0; b < nblk; b++) send({$urandom(), $urandom()}, 1'b0, 0);
            send({$urandom(), $urandom()}, 1'b1, int'($urandom_range(0, 7)));
            release_state();
        end

        // Out-of-range byte count behaves as 7
        load(rand_state());
        send({$urandom(), $urandom()}, 1'b1, 9);
        release_state();

        // Asynchronous reset in the middle of the permutation
        load(rand_state());
        data_i = {$urandom(), $urandom()};
        data_last_i = 1'b0;
        data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        tick();
        tick();
        #2 reset_i = 1'b1;
        #1 chk_reset_outputs("async_rst");
        tick();
        reset_i = 1'b0;
        #1 for (int k = 0; k < 2; k++) chk($sformatf("rerst_sready%0d", k), state_ready_o[k], 1);
        tick();
        load(rand_state());
        send({$urandom(), $urandom()}, 1'b0, 0);
        send({$urandom(), $urandom()}, 1'b1, int'($urandom_range(0, 7)));
        release_state();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/ascon_plaintext_absorb.md
Name: ascon_plaintext_absorb

Overview:
Downstream neighbour of the ASCON-128 initialisation stage. Takes the 320-bit initialised state, then absorbs 64-bit plaintext blocks through a valid/ready handshake. For each block it emits ciphertext (state[0] XOR plaintext) and runs the intermediate permutation. After the padded last block it hands the state to the finalisation stage without permuting.

Parameters:
PERM_ROUNDS, 6, rounds per intermediate permutation (1..12); round-constant index runs 12-PERM_ROUNDS .. 11
DOMAIN_SEP, 1, when 1 XOR 64'h1 into state[4] at state load (domain separation after associated data)

Ports:
clock_i  in  1  system clock, rising edge
reset_i  in  1  asynchronous, active-high reset
state_i  in  320 (type_state)  initialised state from upstream
state_valid_i  in  1  state_i valid
state_ready_o  out  1  block can accept state_i (high only in IDLE)
data_i  in  64  plaintext block, byte 0 = bits [63:56]
data_bytes_i  in  4  valid bytes in data_i; used only when data_last_i=1 (0..7)
data_last_i  in  1  current block is the last (padded) block
data_valid_i  in  1  plaintext handshake valid
data_ready_o  out  1  plaintext handshake ready (high only in ABSORB)
cipher_o  out  64  ciphertext, invalid bytes forced to 0
cipher_bytes_o  out  4  valid ciphertext bytes (8 for non-last blocks)
cipher_valid_o  out  1  one-cycle pulse, no backpressure
state_o  out  320 (type_state)  state for finalisation
state_valid_o  out  1  state_o valid, held until state_ready_i
state_ready_i  in  1  finalisation accepts state_o
busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (async, any state): FSM to IDLE; state register, round counter, cipher_o, cipher_bytes_o all 0; cipher_valid_o, state_valid_o, data_ready_o, busy_o = 0; state_ready_o = 1 once reset is released.
- FSM states: IDLE, ABSORB, PERM, DONE.
- IDLE: state_ready_o=1. On state_valid_i, register state_i. If DOMAIN_SEP, XOR 1 into state[4]. Go to ABSORB.
- ABSORB: data_ready_o=1. Handshake when data_valid_i & data_ready_o.
  - Non-last: c = state[0]^data_i; state[0] <= c; cipher_o <= c; cipher_bytes_o <= 8. Load round counter with 12-PERM_ROUNDS; go to PERM.
  - Last with n = data_bytes_i: pad = 8'h80 at byte n. Mask m keeps bytes 0..n-1. cipher_o <= (state[0]^data_i)&m; cipher_bytes_o <= n. state[0] <= (state[0]^(data_i&m))^pad. Go to DONE.
  - Last with n > 7: treated as n = 7; the bench flags it as a protocol error.
- cipher_valid_o pulses in the cycle after the handshake (latency 1).
- PERM: one round per cycle on the state register, round constant ((15-r)<<4)|r, r = counter. Counter increments each cycle. After the r=11 round, go to ABSORB.
  - Handshake at cycle N: rounds in N+1..N+PERM_ROUNDS; data_ready_o high again at N+PERM_ROUNDS+1.
  - Default throughput: one block per 7 cycles.
- DONE: state_o = state register, state_valid_o=1. Hold until state_ready_i, then go to IDLE. If state_valid_i and state_ready_i are both high in that cycle, only the transfer happens; the new state is taken in the next cycle.
- state_i is ignored outside IDLE. data_valid_i is ignored outside ABSORB.
- state_o reflects the state register in every state; it is meaningful only while state_valid_o=1.
- Empty message: send one last block with n=0. cipher_bytes_o=0, cipher_o=0, and state[0] ^= 64'h8000000000000000.

Decomposition:
- Package ascon_pack: type_state (5 x 64-bit), round-constant function/table indexed 0..11, FSM state enum, padding constant 8'h80.
- Sub-module ascon_round (combinational, single round): state + 4-bit round index in -> constant addition, 5-bit S-box layer, linear diffusion -> state out. Instantiated once.

Test Plan:
- Zero state, DOMAIN_SEP=0, non-last data_i=64'h0123456789ABCDEF -> cipher_o=64'h0123456789ABCDEF, cipher_bytes_o=8, cipher_valid_o one cycle after handshake, data_ready_o low for exactly 6 cycles, then high.
- Zero state, last block n=3, data_i=64'hAABBCCDDEEFF1122 -> cipher_o=64'hAABBCC0000000000, cipher_bytes_o=3; state_o[0]=64'hAABBCC8000000000, state_valid_o high, no PERM cycles.
- Empty last block n=0 on zero state -> cipher_bytes_o=0, cipher_o=0, state_o[0]=64'h8000000000000000.
- DOMAIN_SEP=1, state_i all zero, immediate last n=0 -> state_o[4]=64'h1; 3-block message matches software ASCON-128 reference model ciphertext and state.
- state_ready_i held low 10 cycles in DONE -> state_o stable, state_valid_o high, state_ready_o low; transfer then IDLE next cycle.
- reset_i asserted during PERM round 3 -> all outputs to reset values immediately (async); after release, new state load and block run correctly.
